// File: rtl/gcn_aggregation_fsm_if.sv
// Bus bundle for gcn_aggregation_fsm.
//   COO edge memory port   : coo_address/coo_read out, coo_in {src,dst} back one cycle later
//   Product memory port    : fm_wm_address/fm_wm_read out, fm_wm_row_in back one cycle later
//   Result stream          : out_valid/out_row/out_data out, out_ready back (valid/ready)
// master = aggregation engine, slave = memories plus downstream consumer.
interface gcn_aggregation_fsm_if #(
  parameter int NUM_OF_NODES = 6,
  parameter int WEIGHT_COLS  = 3,
  parameter int NUM_EDGES    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = DATA_WIDTH + $clog2(NUM_EDGES + NUM_OF_NODES + 1),
  parameter int NODE_WIDTH   = $clog2(NUM_OF_NODES),
  parameter int EDGE_WIDTH   = $clog2(NUM_EDGES)
);
  logic [EDGE_WIDTH-1:0]             coo_address;
  logic                              coo_read;
  logic [2*NODE_WIDTH-1:0]           coo_in;
  logic [NODE_WIDTH-1:0]             fm_wm_address;
  logic                              fm_wm_read;
  logic [WEIGHT_COLS*DATA_WIDTH-1:0] fm_wm_row_in;
  logic                              out_valid;
  logic                              out_ready;
  logic [NODE_WIDTH-1:0]             out_row;
  logic [WEIGHT_COLS*ACC_WIDTH-1:0]  out_data;

  modport master (
    output coo_address, coo_read, fm_wm_address, fm_wm_read, out_valid, out_row, out_data,
    input  coo_in, fm_wm_row_in, out_ready
  );

  modport slave (
    input  coo_address, coo_read, fm_wm_address, fm_wm_read, out_valid, out_row, out_data,
    output coo_in, fm_wm_row_in, out_ready
  );
endinterface

// File: rtl/gcn_aggregation_fsm.sv
// gcn_aggregation_fsm: computes OUT = A * FW where A is a COO edge list and FW the
// product memory of the preceding feature x weight stage. Each edge adds row FW[src]
// into accumulator row OUT[dst]; afterwards the NUM_OF_NODES x WEIGHT_COLS result is
// streamed out row by row over a valid/ready handshake.
// Ports:
//   clk          clock, posedge
//   reset        synchronous, active-low
//   start        level start (transformation done)
//   bus          gcn_aggregation_fsm_if.master: COO port, product port, result stream
//   index_error  sticky flag, an edge referenced a node >= NUM_OF_NODES
//   done         run complete, all rows accepted; held until start drops
// Build option: define SELF_LOOP_EN to compute (A+I)*FW (adds one pass over all nodes
// adding FW[n] into OUT[n] before the drain).
module gcn_aggregation_fsm #(
  parameter int NUM_OF_NODES = 6,
  parameter int WEIGHT_COLS  = 3,
  parameter int NUM_EDGES    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = DATA_WIDTH + $clog2(NUM_EDGES + NUM_OF_NODES + 1),
  parameter int NODE_WIDTH   = $clog2(NUM_OF_NODES),
  parameter int EDGE_WIDTH   = $clog2(NUM_EDGES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  gcn_aggregation_fsm_if.master      bus,
  output logic                       index_error,
  output logic                       done
);

  localparam logic [EDGE_WIDTH-1:0] LAST_EDGE = EDGE_WIDTH'(NUM_EDGES - 1);
  localparam logic [NODE_WIDTH-1:0] LAST_NODE = NODE_WIDTH'(NUM_OF_NODES - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_EDGE,
    READ_ROW,
    ACCUMULATE,
`ifdef SELF_LOOP_EN
    SELF_READ,
    SELF_ACC,
`endif
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [EDGE_WIDTH-1:0] edge_cnt;
  logic [NODE_WIDTH-1:0] node_cnt;
  logic [NODE_WIDTH-1:0] src_p1, dst_p1;
  logic [ACC_WIDTH-1:0]  acc [NUM_OF_NODES][WEIGHT_COLS];
  logic                  edge_bad;

  // Unsigned accumulate, wraps modulo 2^ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    return a + ACC_WIDTH'(b);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fw_col(input logic [WEIGHT_COLS*DATA_WIDTH-1:0] row,
                                                   input int c);
    return row[c*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign edge_bad = (32'(src_p1) >= NUM_OF_NODES) || (32'(dst_p1) >= NUM_OF_NODES);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    bus.coo_read      = 1'b0;
    bus.coo_address   = '0;
    bus.fm_wm_read    = 1'b0;
    bus.fm_wm_address = '0;
    bus.out_valid     = 1'b0;
    bus.out_row       = '0;
    bus.out_data      = '0;
    done              = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = READ_EDGE;
      end
      READ_EDGE: begin
        bus.coo_read    = 1'b1;
        bus.coo_address = edge_cnt;
        state_nx        = READ_ROW;
      end
      READ_ROW: begin
        // coo_in is valid now; fetch FW[src] straight from it to save a cycle.
        bus.fm_wm_read    = 1'b1;
        bus.fm_wm_address = bus.coo_in[2*NODE_WIDTH-1:NODE_WIDTH];
        state_nx          = ACCUMULATE;
      end
      ACCUMULATE: begin
        if (edge_cnt == LAST_EDGE) begin
`ifdef SELF_LOOP_EN
          state_nx = SELF_READ;
`else
          state_nx = DRAIN;
`endif
        end else begin
          state_nx = READ_EDGE;
        end
      end
`ifdef SELF_LOOP_EN
      SELF_READ: begin
        bus.fm_wm_read    = 1'b1;
        bus.fm_wm_address = node_cnt;
        state_nx          = SELF_ACC;
      end
      SELF_ACC: begin
        if (node_cnt == LAST_NODE) state_nx = DRAIN;
        else                       state_nx = SELF_READ;
      end
`endif
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_row   = node_cnt;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          bus.out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[node_cnt][c];
        end
        if (bus.out_ready && node_cnt == LAST_NODE) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      edge_cnt    <= '0;
      node_cnt    <= '0;
      src_p1      <= '0;
      dst_p1      <= '0;
      index_error <= 1'b0;
      for (int r = 0; r < NUM_OF_NODES; r++)
        for (int c = 0; c < WEIGHT_COLS; c++) acc[r][c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            edge_cnt    <= '0;
            node_cnt    <= '0;
            index_error <= 1'b0;
            for (int r = 0; r < NUM_OF_NODES; r++)
              for (int c = 0; c < WEIGHT_COLS; c++) acc[r][c] <= '0;
          end
        end
        // Stage boundary: edge {src,dst} captured alongside the product row request.
        READ_ROW: begin
          src_p1 <= bus.coo_in[2*NODE_WIDTH-1:NODE_WIDTH];
          dst_p1 <= bus.coo_in[NODE_WIDTH-1:0];
        end
        // Stage boundary: product row arrives, added into OUT[dst].
        ACCUMULATE: begin
          if (edge_bad) begin
            index_error <= 1'b1;
          end else begin
            for (int c = 0; c < WEIGHT_COLS; c++)
              acc[dst_p1][c] <= acc_add(acc[dst_p1][c], fw_col(bus.fm_wm_row_in, c));
          end
          if (edge_cnt == LAST_EDGE) node_cnt <= '0;
          else                       edge_cnt <= edge_cnt + 1'b1;
        end
`ifdef SELF_LOOP_EN
        SELF_ACC: begin
          for (int c = 0; c < WEIGHT_COLS; c++)
            acc[node_cnt][c] <= acc_add(acc[node_cnt][c], fw_col(bus.fm_wm_row_in, c));
          if (node_cnt == LAST_NODE) node_cnt <= '0;
          else                       node_cnt <= node_cnt + 1'b1;
        end
`endif
        DRAIN: begin
          if (bus.out_ready && node_cnt != LAST_NODE) node_cnt <= node_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_aggregation_fsm.sv
`timescale 1ns/1ps
module tb_gcn_aggregation_fsm;
  localparam int N  = 6;
  localparam int C  = 3;
  localparam int E  = 8;
  localparam int DW = 16;
  localparam int AW = DW + $clog2(E + N + 1);
  localparam int NW = $clog2(N);
  localparam int EW = $clog2(E);
`ifdef SELF_LOOP_EN
  localparam int SELF = 1;
`else
  localparam int SELF = 0;
`endif
  localparam int RUN_CYC = 3*E + N + 1 + SELF*2*N;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic index_error, done;

  always #5 clk = ~clk;

  gcn_aggregation_fsm_if #(.NUM_OF_NODES(N), .WEIGHT_COLS(C), .NUM_EDGES(E), .DATA_WIDTH(DW)) bus ();

  gcn_aggregation_fsm #(.NUM_OF_NODES(N), .WEIGHT_COLS(C), .NUM_EDGES(E), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus.master),
    .index_error(index_error),
    .done(done)
  );

  // Registered memories: data is returned the cycle after the read strobe.
  logic [2*NW-1:0] coo_mem [E];
  logic [C*DW-1:0] fw_mem  [8];

  always @(posedge clk) begin
    if (bus.coo_read)   bus.coo_in       <= coo_mem[bus.coo_address];
    if (bus.fm_wm_read) bus.fm_wm_row_in <= fw_mem[bus.fm_wm_address];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer: drives out_ready on the negedge, records accepted rows, checks hold under stall.
  int bp_mode = 0;
  int bp_phase = 0;
  int n_acc = 0;
  logic [NW-1:0]   got_row  [N];
  logic [C*AW-1:0] got_data [N];
  logic            stalled = 1'b0;
  logic [NW-1:0]   held_row;
  logic [C*AW-1:0] held_data;

  always @(negedge clk) begin
    if (bus.out_valid || done)
      chk("no_read_in_drain_done", {62'd0, bus.coo_read, bus.fm_wm_read}, 64'd0);
    if (bus.out_valid) begin
      if (stalled) begin
        chk("stall_hold_row", 64'(bus.out_row), 64'(held_row));
        chk("stall_hold_data", 64'(bus.out_data), 64'(held_data));
      end
      bus.out_ready = (bp_mode == 0) ? 1'b1 : ((bp_phase % 4 == 0) || (bp_phase % 4 == 3));
      bp_phase++;
      if (bus.out_ready) begin
        if (n_acc < N) begin
          got_row[n_acc]  = bus.out_row;
          got_data[n_acc] = bus.out_data;
        end
        n_acc++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held_row  = bus.out_row;
        held_data = bus.out_data;
      end
    end else begin
      bus.out_ready = 1'b1;
      stalled = 1'b0;
    end
  end

  // Expected row r: hand-entered dst row (e0,e1,e2), plus FW[r]={r,2r,3r} when self loops are on.
  function automatic logic [C*AW-1:0] exp_row(input int r, input int dst,
                                               input int e0, input int e1, input int e2);
    logic [C*AW-1:0] v;
    int col [3];
    v = '0;
    col = '{0, 0, 0};
    if (r == dst) col = '{e0, e1, e2};
    for (int c = 0; c < C; c++) v[c*AW +: AW] = AW'(col[c] + SELF*r*(c+1));
    return v;
  endfunction

  typedef struct {
    string tag;
    int    src;
    int    dst;
    int    bad;     // edge index replaced by {7,1}; -1 for none
    int    bp;      // 1: out_ready pattern 1,0,0,1
    int    e0, e1, e2;
    logic  err;
    int    lat;
  } vec_t;

  vec_t vt [6];

  task automatic load_edges(input int src, input int dst, input int bad);
    for (int e = 0; e < E; e++)
      coo_mem[e] = (e == bad) ? {NW'(7), NW'(1)} : {NW'(src), NW'(dst)};
  endtask

  task automatic run(input vec_t v);
    int cyc;
    load_edges(v.src, v.dst, v.bad);
    bp_mode = v.bp;
    bp_phase = 0;
    n_acc = 0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        chk({v.tag, "_first_coo_read"}, 64'(bus.coo_read), 64'd1);
        chk({v.tag, "_first_coo_addr"}, 64'(bus.coo_address), 64'd0);
      end
    end
    chk({v.tag, "_done_latency"}, 64'(cyc), 64'(v.lat));
    chk({v.tag, "_rows_accepted"}, 64'(n_acc), 64'(N));
    for (int r = 0; r < N; r++) begin
      chk({v.tag, "_row_order"}, 64'(got_row[r]), 64'(r));
      chk({v.tag, "_row_data"}, 64'(got_data[r]), 64'(exp_row(r, v.dst, v.e0, v.e1, v.e2)));
    end
    chk({v.tag, "_index_error"}, 64'(index_error), 64'(v.err));
    @(negedge clk);
    chk({v.tag, "_done_hold"}, 64'(done), 64'd1);
    start = 1'b0;
    @(negedge clk);
    chk({v.tag, "_back_idle"}, 64'(done), 64'd0);
    chk({v.tag, "_err_sticky"}, 64'(index_error), 64'(v.err));
  endtask

  initial begin
    vec_t clean;
    for (int n = 0; n < 8; n++) fw_mem[n] = {DW'(3*n), DW'(2*n), DW'(n)};

    vt[0] = '{tag:"e0to1",  src:0, dst:1, bad:-1, bp:0, e0:0,  e1:0,  e2:0,   err:1'b0, lat:RUN_CYC};
    vt[1] = '{tag:"e2to1",  src:2, dst:1, bad:-1, bp:0, e0:16, e1:32, e2:48,  err:1'b0, lat:RUN_CYC};
    vt[2] = '{tag:"bad3",   src:2, dst:1, bad:3,  bp:0, e0:14, e1:28, e2:42,  err:1'b1, lat:RUN_CYC};
    vt[3] = '{tag:"self3",  src:3, dst:3, bad:-1, bp:0, e0:24, e1:48, e2:72,  err:1'b0, lat:RUN_CYC};
    vt[4] = '{tag:"bp5to0", src:5, dst:0, bad:-1, bp:1, e0:40, e1:80, e2:120, err:1'b0, lat:RUN_CYC+6};
    vt[5] = '{tag:"bad0",   src:4, dst:5, bad:0,  bp:0, e0:28, e1:56, e2:84,  err:1'b1, lat:RUN_CYC};

    // Reset held two cycles with start high.
    reset = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_coo_read",    64'(bus.coo_read), 64'd0);
    chk("rst_fm_wm_read",  64'(bus.fm_wm_read), 64'd0);
    chk("rst_coo_address", 64'(bus.coo_address), 64'd0);
    chk("rst_fm_address",  64'(bus.fm_wm_address), 64'd0);
    chk("rst_out_valid",   64'(bus.out_valid), 64'd0);
    chk("rst_out_data",    64'(bus.out_data), 64'd0);
    chk("rst_done",        64'(done), 64'd0);
    chk("rst_index_error", 64'(index_error), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_coo_read", 64'(bus.coo_read), 64'd0);
    chk("idle_no_fm_read",  64'(bus.fm_wm_read), 64'd0);

    for (int i = 0; i < 6; i++) run(vt[i]);

    // Reset in the middle of ACCUMULATE for edge 4, after edge 3 raised index_error.
    load_edges(2, 1, 3);
    @(negedge clk);
    start = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("midrun_err_set", 64'(index_error), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_err_clr",   64'(index_error), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_coo_read",  64'(bus.coo_read), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    clean = '{tag:"post_rst", src:2, dst:1, bad:-1, bp:0, e0:16, e1:32, e2:48, err:1'b0, lat:RUN_CYC};
    run(clean);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
